// File: rtl/gpu_pkg.sv
// Shared definitions for the core sequencer: state encoding seen by control_unit,
// instruction opcodes and instruction width.
package gpu_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_e;

  localparam logic [3:0] OPCODE_NOP   = 4'h0;
  localparam logic [3:0] OPCODE_BRNZP = 4'h1;
  localparam logic [3:0] OPCODE_CMP   = 4'h2;
  localparam logic [3:0] OPCODE_ADD   = 4'h3;
  localparam logic [3:0] OPCODE_SUB   = 4'h4;
  localparam logic [3:0] OPCODE_MUL   = 4'h5;
  localparam logic [3:0] OPCODE_DIV   = 4'h6;
  localparam logic [3:0] OPCODE_LDR   = 4'h7;
  localparam logic [3:0] OPCODE_STR   = 4'h8;
  localparam logic [3:0] OPCODE_CONST = 4'h9;
  localparam logic [3:0] OPCODE_RET   = 4'hF;

endpackage

// File: rtl/core_scheduler.sv
// Per-core sequencer: fetch over valid/ready, hold in WAIT on memory ops, advance PC.
// Define SCHED_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
//
// state   | meaning
// IDLE    | waiting for start       FETCH   | instruction request outstanding
// DECODE  | control_unit decodes    REQUEST | sample mem_read/mem_write
// WAIT    | data-memory op pending  EXECUTE | ALU / regfile writeback
// UPDATE  | advance pc or finish    DONE    | done held until start drops
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  output logic [2:0]         core_state,
  output logic [3:0]         opcode,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               prog_mem_read_valid,
  output logic [PC_W-1:0]    prog_mem_read_address,
  input  logic               prog_mem_read_ready,
  input  logic [INSTR_W-1:0] prog_mem_read_data,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               program_end,
  output logic               lsu_valid,
  input  logic               lsu_ready,
  output logic               timeout_err
);

  core_state_e        state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               done_q, done_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               lsu_valid_q, lsu_valid_d;

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    done_d        = done_q;
    fetch_valid_d = fetch_valid_q;
    lsu_valid_d   = lsu_valid_q;
`ifdef SCHED_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      CORE_IDLE: begin
        if (start) begin
          state_d       = CORE_FETCH;
          pc_d          = '0;
          fetch_valid_d = 1'b1;
`ifdef SCHED_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      CORE_FETCH: begin
        if (prog_mem_read_ready) begin
          instr_d       = prog_mem_read_data;
          fetch_valid_d = 1'b0;
          state_d       = CORE_DECODE;
        end
      end
      CORE_DECODE: state_d = CORE_REQUEST;
      CORE_REQUEST: begin
        if (mem_read || mem_write) begin
          lsu_valid_d = 1'b1;
          state_d     = CORE_WAIT;
`ifdef SCHED_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
        end else begin
          state_d = CORE_EXECUTE;
        end
      end
      CORE_WAIT: begin
        if (lsu_ready) begin
          lsu_valid_d = 1'b0;
          state_d     = CORE_EXECUTE;
        end
`ifdef SCHED_TIMEOUT_EN
        else begin
          // counter holds the number of WAIT cycles already spent
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
            lsu_valid_d   = 1'b0;
            timeout_err_d = 1'b1;
            done_d        = 1'b1;
            state_d       = CORE_DONE;
          end
        end
`endif
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        if (program_end) begin
          done_d  = 1'b1;
          state_d = CORE_DONE;
        end else begin
          pc_d          = pc_q + 1'b1;
          fetch_valid_d = 1'b1;
          state_d       = CORE_FETCH;
        end
      end
      CORE_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = CORE_IDLE;
        end
      end
      default: state_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= CORE_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      done_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      lsu_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      done_q        <= done_d;
      fetch_valid_q <= fetch_valid_d;
      lsu_valid_q   <= lsu_valid_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_err    = 1'b0;
`endif

  assign core_state            = state_q;
  assign pc                    = pc_q;
  assign instruction           = instr_q;
  assign opcode                = instr_q[INSTR_W-1 -: 4];
  assign done                  = done_q;
  assign prog_mem_read_valid   = fetch_valid_q;
  assign prog_mem_read_address = pc_q;
  assign lsu_valid             = lsu_valid_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: program-memory / control_unit / LSU responders,
// instruction scoreboard, state-trace model and hand-written corner sequences.
module tb_core_scheduler;
  import gpu_pkg::*;

  typedef struct packed {
    logic [7:0][15:0] prog;
    logic [3:0]       n;
    logic [3:0]       rdy;
    logic [4:0]       lsu;
    logic             noise;
    logic [7:0]       exp_cyc;
    logic [7:0]       exp_pc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, done_a, pvalid_a, pready_a, mrd_a, mwr_a, pend_a, lsuv_a, lsur_a, terr_a;
  logic [2:0]  state_a;
  logic [3:0]  opcode_a;
  logic [15:0] instr_a, pdata_a;
  logic [7:0]  pc_a, paddr_a;

  logic        start_b, done_b, pvalid_b, pready_b, mrd_b, mwr_b, pend_b, lsuv_b, lsur_b, terr_b;
  logic [2:0]  state_b;
  logic [3:0]  opcode_b;
  logic [15:0] instr_b, pdata_b;
  logic [1:0]  pc_b, paddr_b;

  core_scheduler #(.PC_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .done(done_a), .core_state(state_a),
    .opcode(opcode_a), .instruction(instr_a), .pc(pc_a),
    .prog_mem_read_valid(pvalid_a), .prog_mem_read_address(paddr_a),
    .prog_mem_read_ready(pready_a), .prog_mem_read_data(pdata_a),
    .mem_read(mrd_a), .mem_write(mwr_a), .program_end(pend_a),
    .lsu_valid(lsuv_a), .lsu_ready(lsur_a), .timeout_err(terr_a)
  );

  core_scheduler #(.PC_W(2), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .done(done_b), .core_state(state_b),
    .opcode(opcode_b), .instruction(instr_b), .pc(pc_b),
    .prog_mem_read_valid(pvalid_b), .prog_mem_read_address(paddr_b),
    .prog_mem_read_ready(pready_b), .prog_mem_read_data(pdata_b),
    .mem_read(mrd_b), .mem_write(mwr_b), .program_end(pend_b),
    .lsu_valid(lsuv_b), .lsu_ready(lsur_b), .timeout_err(terr_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] prog_a [256];
  logic [15:0] prog_b [16];
  logic [15:0] sb_a [$];
  logic [2:0]  trace_a [$];
  logic [2:0]  exp_tr [$];
  logic [15:0] last_instr_a;
  int          rdy_dly_a, lsu_dly_a, fcnt_a, lcnt_a, fidx_b;
  logic        noise_a, tracing;
  vec_t        vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

  function automatic vec_t mkv(input int n, input int rdy, input int lsu, input logic noise,
                               input int cyc, input int pc,
                               input logic [15:0] i0, i1, i2, i3, i4, i5, i6);
    vec_t v;
    v = '0;
    v.prog[0] = i0; v.prog[1] = i1; v.prog[2] = i2; v.prog[3] = i3;
    v.prog[4] = i4; v.prog[5] = i5; v.prog[6] = i6;
    v.n = 4'(n); v.rdy = 4'(rdy); v.lsu = 5'(lsu); v.noise = noise;
    v.exp_cyc = 8'(cyc); v.exp_pc = 8'(pc);
    return v;
  endfunction

  // One clock: sample outputs 1 time unit after the edge, check, then drive responders.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (tracing) trace_a.push_back(state_a);
    check("a_fetch_valid", {31'b0, pvalid_a}, {31'b0, state_a == CORE_FETCH});
    check("a_fetch_addr", {24'b0, paddr_a}, {24'b0, pc_a});
    check("a_lsu_valid", {31'b0, lsuv_a}, {31'b0, state_a == CORE_WAIT});
    check("a_done", {31'b0, done_a}, {31'b0, state_a == CORE_DONE});
    check("a_timeout_err", {31'b0, terr_a}, 32'd0);
    if (state_a == CORE_FETCH) check("a_instr_hold", {16'b0, instr_a}, {16'b0, last_instr_a});
    if (state_a == CORE_DECODE) begin
      check("a_sb_level", sb_a.size(), 32'd1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        check("a_instr", {16'b0, instr_a}, {16'b0, e});
        check("a_opcode", {28'b0, opcode_a}, {28'b0, e[15:12]});
        last_instr_a = e;
      end
    end

    if (pvalid_a) begin
      pready_a = (fcnt_a == rdy_dly_a);
      pdata_a  = pready_a ? prog_a[paddr_a] : (16'hBAD0 ^ 16'(fcnt_a));
      if (pready_a) sb_a.push_back(prog_a[paddr_a]);
      fcnt_a++;
    end else begin
      pready_a = 1'b0;
      pdata_a  = 16'hBAD0;
      fcnt_a   = 0;
    end
    mrd_a  = (state_a == CORE_REQUEST) && (opcode_a == OPCODE_LDR);
    mwr_a  = (state_a == CORE_REQUEST) && (opcode_a == OPCODE_STR);
    pend_a = (state_a == CORE_UPDATE) && (opcode_a == OPCODE_RET);
    if (state_a == CORE_WAIT) begin
      lcnt_a++;
      lsur_a = (lcnt_a == lsu_dly_a);
    end else begin
      lcnt_a = 0;
      lsur_a = noise_a;
    end

    if (pvalid_b) begin
      pready_b = 1'b1;
      pdata_b  = prog_b[fidx_b % 16];
      check("b_fetch_addr", {30'b0, paddr_b}, {30'b0, 2'(fidx_b)});
      fidx_b++;
    end else begin
      pready_b = 1'b0;
      pdata_b  = 16'h0;
    end
    mrd_b  = (state_b == CORE_REQUEST) && (opcode_b == OPCODE_LDR);
    mwr_b  = 1'b0;
    pend_b = (state_b == CORE_UPDATE) && (opcode_b == OPCODE_RET);
    lsur_b = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    sb_a.delete();
    fcnt_a = 0; lcnt_a = 0; fidx_b = 0; last_instr_a = '0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc, mism;
    bit   seen, finished;
    logic [3:0] op;
    do_reset();
    for (int i = 0; i < 256; i++) prog_a[i] = 16'h0;
    for (int i = 0; i < 8; i++) prog_a[i] = v.prog[i];
    rdy_dly_a = int'(v.rdy);
    lsu_dly_a = int'(v.lsu);
    noise_a   = v.noise;
    trace_a.delete();
    tracing  = 1'b1;
    start_a  = 1'b1;
    cyc = 0; seen = 0; finished = 0;
    for (int t = 0; t < 400 && !finished; t++) begin
      tick();
      if (seen) cyc++;
      if (state_a == CORE_FETCH) seen = 1;
      if (state_a == CORE_DONE) finished = 1;
    end
    tracing = 1'b0;
    check($sformatf("v%0d_done_reached", idx), {31'b0, finished}, 32'd1);
    check($sformatf("v%0d_cycles", idx), cyc, {24'b0, v.exp_cyc});
    check($sformatf("v%0d_pc", idx), {24'b0, pc_a}, {24'b0, v.exp_pc});

    exp_tr.delete();
    for (int i = 0; i < int'(v.n); i++) begin
      op = v.prog[i][15:12];
      for (int k = 0; k <= int'(v.rdy); k++) exp_tr.push_back(CORE_FETCH);
      exp_tr.push_back(CORE_DECODE);
      exp_tr.push_back(CORE_REQUEST);
      if (op == OPCODE_LDR || op == OPCODE_STR)
        for (int k = 0; k < int'(v.lsu); k++) exp_tr.push_back(CORE_WAIT);
      exp_tr.push_back(CORE_EXECUTE);
      exp_tr.push_back(CORE_UPDATE);
    end
    exp_tr.push_back(CORE_DONE);
    check($sformatf("v%0d_trace_len", idx), trace_a.size(), exp_tr.size());
    mism = 0;
    for (int i = 0; i < trace_a.size() && i < exp_tr.size(); i++)
      if (trace_a[i] !== exp_tr[i]) mism++;
    check($sformatf("v%0d_trace_states", idx), mism, 32'd0);

    tick();
    check($sformatf("v%0d_done_held", idx), {31'b0, done_a}, 32'd1);
    start_a = 1'b0;
    tick();
    check($sformatf("v%0d_back_idle", idx), {29'b0, state_a}, 32'd0);
  endtask

  initial begin
    int   cyc, wcnt;
    bit   seen, finished, found, wrapped;
    logic [1:0] prev_pc;

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    pready_a = 0; pdata_a = 0; mrd_a = 0; mwr_a = 0; pend_a = 0; lsur_a = 0;
    pready_b = 0; pdata_b = 0; mrd_b = 0; mwr_b = 0; pend_b = 0; lsur_b = 0;
    tracing = 0; noise_a = 0; rdy_dly_a = 0; lsu_dly_a = 0;
    fcnt_a = 0; lcnt_a = 0; fidx_b = 0; last_instr_a = '0;
    for (int i = 0; i < 16; i++) prog_b[i] = 16'h0;

    vecs[0] = mkv(3, 0, 0, 0, 15, 2, ins(OPCODE_CONST, 12'h005), ins(OPCODE_ADD, 12'h123),
                  ins(OPCODE_RET, 12'h0), 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[1] = mkv(3, 3, 0, 0, 24, 2, ins(OPCODE_CONST, 12'h005), ins(OPCODE_ADD, 12'h123),
                  ins(OPCODE_RET, 12'h0), 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[2] = mkv(2, 0, 10, 0, 20, 1, ins(OPCODE_LDR, 12'h0A1), ins(OPCODE_RET, 12'h0),
                  16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[3] = mkv(4, 1, 2, 1, 28, 3, ins(OPCODE_STR, 12'h321), ins(OPCODE_ADD, 12'h456),
                  ins(OPCODE_LDR, 12'h789), ins(OPCODE_RET, 12'h0), 16'h0, 16'h0, 16'h0);
    vecs[4] = mkv(1, 0, 0, 0, 5, 0, ins(OPCODE_RET, 12'h0), 16'h0, 16'h0, 16'h0,
                  16'h0, 16'h0, 16'h0);
    vecs[5] = mkv(7, 2, 0, 0, 49, 6, ins(OPCODE_NOP, 12'h111), ins(OPCODE_SUB, 12'h222),
                  ins(OPCODE_CMP, 12'h333), ins(OPCODE_MUL, 12'h444), ins(OPCODE_CONST, 12'h555),
                  ins(OPCODE_DIV, 12'h666), ins(OPCODE_RET, 12'h0));

    repeat (2) tick();
    check("rst_state", {29'b0, state_a}, 32'd0);
    check("rst_pc", {24'b0, pc_a}, 32'd0);
    check("rst_instr", {16'b0, instr_a}, 32'd0);
    check("rst_fetch_valid", {31'b0, pvalid_a}, 32'd0);
    check("rst_lsu_valid", {31'b0, lsuv_a}, 32'd0);
    check("rst_b_state", {29'b0, state_b}, 32'd0);
    check("rst_b_timeout_err", {31'b0, terr_b}, 32'd0);

    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

    // Reset asserted in the middle of a WAIT, start held high throughout.
    do_reset();
    for (int i = 0; i < 256; i++) prog_a[i] = 16'h0;
    prog_a[0] = ins(OPCODE_LDR, 12'h042);
    prog_a[1] = ins(OPCODE_RET, 12'h0);
    rdy_dly_a = 0; lsu_dly_a = 0; noise_a = 0;
    start_a = 1'b1;
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      tick();
      if (state_a == CORE_WAIT) found = 1;
    end
    check("mr_wait_reached", {31'b0, found}, 32'd1);
    repeat (3) tick();
    check("mr_still_wait", {29'b0, state_a}, {29'b0, CORE_WAIT});
    #2;
    reset = 1'b0;
    #1;
    check("mr_state", {29'b0, state_a}, 32'd0);
    check("mr_lsu_valid", {31'b0, lsuv_a}, 32'd0);
    check("mr_fetch_valid", {31'b0, pvalid_a}, 32'd0);
    check("mr_pc", {24'b0, pc_a}, 32'd0);
    check("mr_instr", {16'b0, instr_a}, 32'd0);
    check("mr_done", {31'b0, done_a}, 32'd0);
    tick();
    sb_a.delete();
    last_instr_a = '0;
    fcnt_a = 0;
    lsu_dly_a = 3;
    reset = 1'b1;
    tick();
    check("mr_restart_fetch", {29'b0, state_a}, {29'b0, CORE_FETCH});
    check("mr_restart_pc", {24'b0, pc_a}, 32'd0);
    finished = 0;
    for (int t = 0; t < 100 && !finished; t++) begin
      tick();
      if (state_a == CORE_DONE) finished = 1;
    end
    check("mr_done_reached", {31'b0, finished}, 32'd1);
    check("mr_final_pc", {24'b0, pc_a}, 32'd1);
    start_a = 1'b0;
    tick();

    // PC_W=2: five non-RET instructions then RET fetched from address 1 after wrap.
    prog_b[0] = ins(OPCODE_CONST, 12'h001);
    prog_b[1] = ins(OPCODE_ADD, 12'h002);
    prog_b[2] = ins(OPCODE_SUB, 12'h003);
    prog_b[3] = ins(OPCODE_NOP, 12'h004);
    prog_b[4] = ins(OPCODE_MUL, 12'h005);
    prog_b[5] = ins(OPCODE_RET, 12'h0);
    fidx_b = 0;
    start_b = 1'b1;
    cyc = 0; seen = 0; finished = 0; wrapped = 0; prev_pc = 2'd0;
    for (int t = 0; t < 200 && !finished; t++) begin
      tick();
      if (seen) cyc++;
      if (state_b == CORE_FETCH) seen = 1;
      if (prev_pc == 2'd3 && pc_b == 2'd0) wrapped = 1;
      prev_pc = pc_b;
      if (state_b == CORE_DONE) finished = 1;
    end
    check("wrap_done_reached", {31'b0, finished}, 32'd1);
    check("wrap_cycles", cyc, 32'd30);
    check("wrap_pc", {30'b0, pc_b}, 32'd1);
    check("wrap_fetches", fidx_b, 32'd6);
    check("wrap_seen", {31'b0, wrapped}, 32'd1);
    check("wrap_done", {31'b0, done_b}, 32'd1);
    start_b = 1'b0;
    tick();
    check("wrap_idle", {29'b0, state_b}, 32'd0);

    // LOAD whose lsu_ready never arrives, TIMEOUT=4.
    for (int i = 0; i < 16; i++) prog_b[i] = 16'h0;
    prog_b[0] = ins(OPCODE_LDR, 12'h0F0);
    fidx_b = 0;
    start_b = 1'b1;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (state_b == CORE_WAIT) found = 1;
    end
    check("to_wait_reached", {31'b0, found}, 32'd1);
    wcnt = 1;
    for (int t = 0; t < 19; t++) begin
      tick();
      if (state_b != CORE_WAIT) break;
      wcnt++;
    end
`ifdef SCHED_TIMEOUT_EN
    check("to_wait_cycles", wcnt, 32'd4);
    check("to_state_done", {29'b0, state_b}, {29'b0, CORE_DONE});
    check("to_err", {31'b0, terr_b}, 32'd1);
    check("to_done", {31'b0, done_b}, 32'd1);
    check("to_lsu_valid", {31'b0, lsuv_b}, 32'd0);
    start_b = 1'b0;
    tick();
    check("to_idle", {29'b0, state_b}, 32'd0);
    check("to_err_sticky", {31'b0, terr_b}, 32'd1);
    check("to_done_clear", {31'b0, done_b}, 32'd0);
    start_b = 1'b1;
    tick();
    check("to_refetch", {29'b0, state_b}, {29'b0, CORE_FETCH});
    check("to_err_cleared", {31'b0, terr_b}, 32'd0);
`else
    check("nto_wait_cycles", wcnt, 32'd20);
    check("nto_state_wait", {29'b0, state_b}, {29'b0, CORE_WAIT});
    check("nto_lsu_valid", {31'b0, lsuv_b}, 32'd1);
    check("nto_err", {31'b0, terr_b}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
